bram_port_arbiter: RTL and testbench

//  Shares one port of the 16K x 32 true-dual-port block RAM between NUM_REQ requesters.

---
 rtl/bram_port_arbiter_pkg.sv | 23 ++
 rtl/bram_port_arbiter_rr_priority_pick.sv | 41 ++++
 rtl/bram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port arbiter.
//   arb_state_e : arbiter FSM encoding (free arbitration vs. held lock)
//   Def*        : default geometry for a 16K x 32 RAM port with 4 requesters
//   idx_w()     : index width for a requester count (never below 1 bit)
package bram_port_arbiter_pkg;

  typedef enum logic [0:0] {
    StArb    = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefAddrW  = 14;
  localparam int unsigned DefDataW  = 32;

  // Lock idle counter width; covers timeouts up to 255 cycles.
  localparam int unsigned LockCntW  = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
//   req_i : request vector
//   ptr_i : highest-priority position; search proceeds upward and wraps
//   gnt_o : one-hot grant of the first set request at or after ptr_i, 0 if none
//   idx_o : binary index of gnt_o (0 when gnt_o is 0)
module bram_port_arbiter_rr_priority_pick
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = DefNumReq,
  parameter int unsigned IdxW   = idx_w(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    int unsigned     pos;
    found = 1'b0;
    cand  = '0;
    pos   = 0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NumReq) begin
        pos = pos - NumReq;
      end
      cand = IdxW'(pos);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one port of a true-dual-port block RAM between NumReq requesters.
//   clk_i / rst_i        : clock, asynchronous active-high reset
//   req_valid_i/ready_o  : per-requester handshake; ready is a one-hot grant
//   req_we_i, req_lock_i : op type and "keep grant after this op"
//   req_addr_i/wdata_i   : packed per-requester command fields
//   rsp_valid_o/rdata_o  : one-hot read-data strobe and data, 2 edges after accept
//   bram_*               : registered command to the RAM port, registered read data back
// Arbitration is round-robin; a lock pins the grant to its owner until the owner
// issues an unlocked op or stays idle for LockTimeout consecutive cycles.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = DefNumReq,
  parameter int unsigned AddrW       = DefAddrW,
  parameter int unsigned DataW       = DefDataW,
  parameter int unsigned LockTimeout = 15,
  localparam int unsigned IdxW       = idx_w(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq-1:0]       req_we_i,
  input  logic [NumReq-1:0]       req_lock_i,
  input  logic [NumReq*AddrW-1:0] req_addr_i,
  input  logic [NumReq*DataW-1:0] req_wdata_i,
  output logic [NumReq-1:0]       rsp_valid_o,
  output logic [DataW-1:0]        rsp_rdata_o,
  output logic                    bram_we_o,
  output logic [AddrW-1:0]        bram_addr_o,
  output logic [DataW-1:0]        bram_din_o,
  input  logic [DataW-1:0]        bram_dout_i
);

  function automatic logic [NumReq-1:0] to_oh(input logic [IdxW-1:0] i);
    logic [NumReq-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  arb_state_e          state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     owner_q;
  logic [LockCntW-1:0] lock_cnt_q;

  logic                bram_we_q;
  logic [AddrW-1:0]    bram_addr_q;
  logic [DataW-1:0]    bram_din_q;

  // Read tag pipe: stage 1 travels with the RAM command, stage 2 with the RAM read.
  logic                rd1_vld_q;
  logic [IdxW-1:0]     rd1_idx_q;
  logic                rd2_vld_q;
  logic [IdxW-1:0]     rd2_idx_q;
  logic [NumReq-1:0]   rsp_valid_q;
  logic [DataW-1:0]    rsp_rdata_q;

  logic [NumReq-1:0]   pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic [NumReq-1:0]   ready;
  logic [IdxW-1:0]     gnt_idx;
  logic                accept;
  logic                acc_we;
  logic                acc_lock;
  logic [AddrW-1:0]    acc_addr;
  logic [DataW-1:0]    acc_wdata;
  logic [IdxW-1:0]     next_ptr;

  bram_port_arbiter_rr_priority_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    if (state_q == StLocked) begin
      gnt_idx = owner_q;
      ready   = to_oh(owner_q) & req_valid_i;
    end else begin
      gnt_idx = pick_idx;
      ready   = pick_gnt;
    end
    accept    = |ready;
    acc_we    = req_we_i[gnt_idx];
    acc_lock  = req_lock_i[gnt_idx];
    acc_addr  = req_addr_i[32'(gnt_idx)*AddrW +: AddrW];
    acc_wdata = req_wdata_i[32'(gnt_idx)*DataW +: DataW];
    next_ptr  = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : IdxW'(gnt_idx + 1'b1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StArb;
      ptr_q       <= '0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      rd1_vld_q   <= 1'b0;
      rd1_idx_q   <= '0;
      rd2_vld_q   <= 1'b0;
      rd2_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      // Command stage; address and data hold their last value when idle.
      bram_we_q <= accept & acc_we;
      if (accept) begin
        bram_addr_q <= acc_addr;
        bram_din_q  <= acc_wdata;
        rd1_idx_q   <= gnt_idx;
      end
      rd1_vld_q <= accept & ~acc_we;

      // RAM samples the command at the next edge; its registered output is
      // valid one edge later, where it is captured together with the tag.
      rd2_vld_q   <= rd1_vld_q;
      rd2_idx_q   <= rd1_idx_q;
      rsp_valid_q <= rd2_vld_q ? to_oh(rd2_idx_q) : '0;
      if (rd2_vld_q) begin
        rsp_rdata_q <= bram_dout_i;
      end

      unique case (state_q)
        StArb: begin
          if (accept) begin
            ptr_q <= next_ptr;
            if (acc_lock) begin
              state_q    <= StLocked;
              owner_q    <= gnt_idx;
              lock_cnt_q <= '0;
            end
          end
        end
        StLocked: begin
          // In this state accept is exactly "owner valid".
          if (accept) begin
            lock_cnt_q <= '0;
            if (!acc_lock) begin
              state_q <= StArb;
              ptr_q   <= next_ptr;
            end
          end else if (lock_cnt_q == LockCntW'(LockTimeout - 1)) begin
            state_q    <= StArb;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign req_ready_o = ready;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign bram_we_o   = bram_we_q;
  assign bram_addr_o = bram_addr_q;
  assign bram_din_o  = bram_din_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a behavioural registered RAM.
module tb_bram_port_arbiter;

  localparam int unsigned NumReq      = 4;
  localparam int unsigned AddrW       = 14;
  localparam int unsigned DataW       = 32;
  localparam int unsigned LockTimeout = 15;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NumReq-1:0]       req_valid;
  logic [NumReq-1:0]       req_ready;
  logic [NumReq-1:0]       req_we;
  logic [NumReq-1:0]       req_lock;
  logic [NumReq*AddrW-1:0] req_addr;
  logic [NumReq*DataW-1:0] req_wdata;
  logic [NumReq-1:0]       rsp_valid;
  logic [DataW-1:0]        rsp_rdata;
  logic                    bram_we;
  logic [AddrW-1:0]        bram_addr;
  logic [DataW-1:0]        bram_din;
  logic [DataW-1:0]        bram_dout;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .NumReq      (NumReq),
    .AddrW       (AddrW),
    .DataW       (DataW),
    .LockTimeout (LockTimeout)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_lock_i  (req_lock),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .bram_we_o   (bram_we),
    .bram_addr_o (bram_addr),
    .bram_din_o  (bram_din),
    .bram_dout_i (bram_dout)
  );

  // Registered-output, read-first RAM port.
  logic [DataW-1:0] bram_mem [0:(1<<AddrW)-1];
  always @(posedge clk) begin
    if (bram_we) bram_mem[bram_addr] <= bram_din;
    bram_dout <= bram_mem[bram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int unsigned      idx;
    logic [DataW-1:0] data;
    int               at;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [DataW-1:0] ref_mem [int];

  // Response side of the scoreboard.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid=%b rdata=%h, nothing outstanding",
                 rsp_valid, rsp_rdata);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_valid !== (NumReq'(1) << mon_e.idx) || rsp_rdata !== mon_e.data ||
            cyc != mon_e.at) begin
          n_fail++;
          $display("FAIL rsp: got valid=%b data=%h cycle=%0d, expected valid=%b data=%h cycle=%0d",
                   rsp_valid, rsp_rdata, cyc, NumReq'(1) << mon_e.idx, mon_e.data, mon_e.at);
        end
      end
    end else if (sb.size() != 0 && sb[0].at < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_missing: got no rsp at cycle %0d, expected requester %0d data=%h",
               sb[0].at, sb[0].idx, sb[0].data);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
    req_valid[i]                  = v;
    req_we[i]                     = we;
    req_lock[i]                   = lk;
    req_addr[i*AddrW +: AddrW]    = a;
    req_wdata[i*DataW +: DataW]   = d;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  // One clock: sample the grant at negedge, record accepted ops, return #1 after posedge.
  task automatic step(output logic [NumReq-1:0] g);
    logic [AddrW-1:0] a;
    @(negedge clk);
    g = req_ready;
    for (int i = 0; i < NumReq; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        a = req_addr[i*AddrW +: AddrW];
        if (req_we[i]) ref_mem[int'(a)] = req_wdata[i*DataW +: DataW];
        else sb.push_back('{idx: i, data: ref_mem[int'(a)], at: cyc + 3});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NumReq-1:0] g;
    rst = 1'b1;
    idle_all();
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bram_we, bram_addr, bram_din, rsp_valid, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%h din=%h rv=%b rd=%h, expected all 0",
               bram_we, bram_addr, bram_din, rsp_valid, rsp_rdata);
    end
    n_chk++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    rst = 1'b0;

    set_req(0, 1'b1, 1'b1, 1'b0, 14'h0005, 32'hA5A5_A5A5);
    step(g);
    n_chk++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_wr_grant: got %b expected 0001", g);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 14'h0005, 32'h0);
    step(g);
    n_chk++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_rd_grant: got %b expected 0001", g);
    end
    // Read in flight; reset lands before its response.
    idle_all();
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    n_chk++;
    if ({bram_we, bram_addr, bram_din, rsp_valid, rsp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got we=%b addr=%h din=%h rv=%b rd=%h, expected all 0",
               bram_we, bram_addr, bram_din, rsp_valid, rsp_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(g);
      n_chk++;
      if ({g, bram_we, bram_addr, bram_din, rsp_valid, rsp_rdata} !== '0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: got g=%b we=%b addr=%h din=%h rv=%b rd=%h, expected 0",
                 g, bram_we, bram_addr, bram_din, rsp_valid, rsp_rdata);
      end
    end

    // Reset while a lock is held.
    set_req(1, 1'b1, 1'b0, 1'b1, 14'h0005, 32'h0);
    step(g);
    n_chk++;
    if (g !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_grant: got %b expected 0010", g);
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 14'h0005, 32'h0);
    set_req(0, 1'b1, 1'b0, 1'b0, 14'h0005, 32'h0);
    step(g);
    n_chk++;
    if (g !== 4'b0000) begin
      n_fail++;
      $display("FAIL lock_stall: got %b expected 0000", g);
    end
    #2;
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(g);
    n_chk++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_mid_lock: got %b expected 0001", g);
    end
    idle_all();
    repeat (3) step(g);
  endtask

  task automatic test_write_readback();
    logic [NumReq-1:0] g;
    set_req(0, 1'b1, 1'b1, 1'b0, 14'h3FFF, 32'hDEAD_BEEF);
    step(g);
    n_chk++;
    if (g !== 4'b0001 || bram_we !== 1'b1 || bram_addr !== 14'h3FFF ||
        bram_din !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_cmd: got g=%b we=%b addr=%h din=%h, expected 0001 1 3fff deadbeef",
               g, bram_we, bram_addr, bram_din);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 14'h3FFF, 32'h0);
    step(g);
    n_chk++;
    if (g !== 4'b0001 || bram_we !== 1'b0 || bram_addr !== 14'h3FFF) begin
      n_fail++;
      $display("FAIL rd_cmd: got g=%b we=%b addr=%h, expected 0001 0 3fff", g, bram_we, bram_addr);
    end
    idle_all();
    step(g);
    n_chk++;
    if (bram_we !== 1'b0 || bram_addr !== 14'h3FFF || rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_hold: got we=%b addr=%h rv=%b, expected 0 3fff 0000",
               bram_we, bram_addr, rsp_valid);
    end
    step(g);
    n_chk++;
    if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL readback: got rv=%b rd=%h, expected 0001 deadbeef", rsp_valid, rsp_rdata);
    end
    step(g);
    n_chk++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL rsp_one_cycle: got %b expected 0000", rsp_valid);
    end
  endtask

  task automatic test_fairness();
    logic [NumReq-1:0] g;
    for (int k = 0; k < 8; k++) begin
      set_req(3, 1'b1, 1'b1, 1'b0, AddrW'(14'h0100 + k), 32'hF00D_0000 + k);
      step(g);
      n_chk++;
      if (g !== 4'b1000) begin
        n_fail++;
        $display("FAIL fair_prefill: got %b expected 1000", g);
      end
    end
    idle_all();
    // Pointer now sits at 0; all four read every cycle.
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < NumReq; r++) begin
        set_req(r, 1'b1, 1'b0, 1'b0, AddrW'(14'h0100 + (k / 4) * 4 + r), 32'h0);
      end
      step(g);
      n_chk++;
      if (g !== (4'b0001 << (k % 4))) begin
        n_fail++;
        $display("FAIL fair_order: step %0d got %b expected %b", k, g, 4'b0001 << (k % 4));
      end
    end
    idle_all();
    repeat (3) step(g);
  endtask

  task automatic test_lock_rmw();
    logic [NumReq-1:0] g;
    set_req(3, 1'b1, 1'b1, 1'b0, 14'h0010, 32'h0BAD_F00D);
    step(g);
    idle_all();
    set_req(2, 1'b1, 1'b0, 1'b1, 14'h0010, 32'h0);
    step(g);
    n_chk++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmw_lock_grant: got %b expected 0100", g);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 14'h0010, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 14'h0010, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b0, 14'h0010, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step(g);
      n_chk++;
      if (g !== 4'b0100) begin
        n_fail++;
        $display("FAIL rmw_locked: got %b expected 0100", g);
      end
    end
    set_req(2, 1'b0, 1'b0, 1'b1, 14'h0010, 32'h0);
    step(g);
    n_chk++;
    if (g !== 4'b0000) begin
      n_fail++;
      $display("FAIL rmw_owner_idle: got %b expected 0000", g);
    end
    set_req(2, 1'b1, 1'b1, 1'b0, 14'h0010, 32'h1234_5678);
    step(g);
    n_chk++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmw_unlock_write: got %b expected 0100", g);
    end
    set_req(2, 1'b0, 1'b0, 1'b0, 14'h0010, 32'h0);
    step(g);
    n_chk++;
    if (g !== 4'b1000) begin
      n_fail++;
      $display("FAIL rmw_next_req3: got %b expected 1000", g);
    end
    idle_all();
    repeat (3) step(g);
  endtask

  task automatic test_lock_timeout();
    logic [NumReq-1:0] g;
    int stalled;
    set_req(1, 1'b1, 1'b1, 1'b1, 14'h0020, 32'h2020_2020);
    step(g);
    n_chk++;
    if (g !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout_lock_grant: got %b expected 0010", g);
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 14'h0020, 32'h0);
    set_req(0, 1'b1, 1'b0, 1'b0, 14'h0020, 32'h0);
    stalled = 0;
    g = '0;
    while (stalled < 40) begin
      step(g);
      if (g !== '0) break;
      stalled++;
    end
    n_chk++;
    if (stalled != LockTimeout || g !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_timeout: got stalled=%0d g=%b, expected stalled=%0d g=0001",
               stalled, g, LockTimeout);
    end
    idle_all();
    repeat (3) step(g);
  endtask

  task automatic test_back_to_back();
    logic [NumReq-1:0] g;
    logic              we;
    logic [AddrW-1:0]  a;
    for (int k = 0; k < 16; k++) begin
      set_req(3, 1'b1, 1'b1, 1'b0, AddrW'(14'h0200 + k), $urandom);
      step(g);
      n_chk++;
      if (g !== 4'b1000) begin
        n_fail++;
        $display("FAIL b2b_prefill: got %b expected 1000", g);
      end
    end
    for (int k = 0; k < 100; k++) begin
      we = 1'($urandom_range(0, 1));
      a  = AddrW'(14'h0200 + $urandom_range(0, 15));
      set_req(3, 1'b1, we, 1'b0, a, $urandom);
      step(g);
      n_chk++;
      if (g !== 4'b1000) begin
        n_fail++;
        $display("FAIL b2b_grant: op %0d got %b expected 1000", k, g);
      end
    end
    idle_all();
    repeat (4) step(g);
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_write_readback();
    test_fairness();
    test_lock_rmw();
    test_lock_timeout();
    test_back_to_back();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
